// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// baud-tick divider calculation.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_RESYNC
    } rx_state_t;

    // Clock cycles per oversample tick, truncated.
    function automatic int calc_div(input int clock_rate, input int baud_rate,
                                    input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with synchronous clear; one-cycle
// tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    output logic o_tick
);

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_LAST);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority vote, parity check, framing
// and break detection, and a resync wait after a low stop bit.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxEn,
    input  logic                 rx,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic                 rxBreak,
    output logic [DATA_BITS-1:0] out
);

    localparam int              DIV       = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int              PH_W      = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_V0     = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_V1     = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_V2     = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t            r_state, w_state_nxt;
    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [PH_W-1:0]      r_phase, w_phase_nxt;
    logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]           r_votes, w_votes_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_out, w_out_nxt;
    logic                 r_par_bit, w_par_bit_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 r_brk, w_brk_nxt;

    logic w_rxs, w_tick, w_start_det, w_vote, w_wrap, w_maj, w_par_exp;

    assign w_rxs       = r_sync[1];
    assign w_start_det = (r_state == RX_IDLE) && rxEn && r_prev && !w_rxs;
    assign w_vote      = w_tick && (r_phase == PH_V2);
    assign w_wrap      = w_tick && (r_phase == PH_LAST);
    assign w_maj       = (r_votes[0] & r_votes[1]) | (r_votes[0] & w_rxs) | (r_votes[1] & w_rxs);
    assign w_par_exp   = (PARITY == PARITY_ODD) ? ~^r_shift : ^r_shift;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (w_start_det),
        .o_tick (w_tick)
    );

    // NOTE: every variable gets its default at the top of the block, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_bit_cnt_nxt = r_bit_cnt;
        w_votes_nxt   = r_votes;
        w_shift_nxt   = r_shift;
        w_out_nxt     = r_out;
        w_par_bit_nxt = r_par_bit;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_perr_nxt    = r_perr;
        w_brk_nxt     = r_brk;

        if (w_tick && r_phase == PH_V0) w_votes_nxt[0] = w_rxs;
        if (w_tick && r_phase == PH_V1) w_votes_nxt[1] = w_rxs;
        if (w_tick) w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);

        if (!rxEn) begin
            w_state_nxt = RX_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                RX_IDLE: begin
                    if (w_start_det) begin
                        w_state_nxt   = RX_START;
                        w_phase_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_par_bit_nxt = 1'b0;
                        w_busy_nxt    = 1'b1;
                        w_err_nxt     = 1'b0;
                        w_perr_nxt    = 1'b0;
                        w_brk_nxt     = 1'b0;
                    end
                end
                RX_START: begin
                    if (w_vote && w_maj) begin
                        w_state_nxt = RX_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else if (w_wrap) begin
                        w_state_nxt = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_vote) w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_wrap) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_vote) begin
                        w_par_bit_nxt = w_maj;
                        w_perr_nxt    = (w_maj != w_par_exp);
                    end
                    if (w_wrap) w_state_nxt = RX_STOP;
                end
                RX_STOP: begin
                    if (w_vote && (!w_maj || r_bit_cnt == STOP_LAST)) begin
                        w_out_nxt  = r_shift;
                        w_done_nxt = 1'b1;
                        if (!w_maj) begin
                            w_err_nxt   = 1'b1;
                            w_brk_nxt   = (r_bit_cnt == '0) && (r_shift == '0) && !r_par_bit;
                            w_state_nxt = RX_RESYNC;
                            w_phase_nxt = '0;
                        end else begin
                            w_state_nxt = RX_IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end else if (w_wrap) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
                RX_RESYNC: begin
                    // Phase counts consecutive high ticks; any low cycle restarts it.
                    w_phase_nxt = r_phase;
                    if (!w_rxs) begin
                        w_phase_nxt = '0;
                    end else if (w_tick) begin
                        if (r_phase == PH_LAST) begin
                            w_state_nxt = RX_IDLE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_phase_nxt = r_phase + PH_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = RX_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Synchronizer flops reset high so the idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync    <= 2'b11;
            r_prev    <= 1'b1;
            r_state   <= RX_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_votes   <= '0;
            r_shift   <= '0;
            r_out     <= '0;
            r_par_bit <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_perr    <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_prev    <= w_rxs;
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_votes   <= w_votes_nxt;
            r_shift   <= w_shift_nxt;
            r_out     <= w_out_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_perr    <= w_perr_nxt;
            r_brk     <= w_brk_nxt;
        end
    end

    assign rxBusy      = r_busy;
    assign rxDone      = r_done;
    assign rxErr       = r_err;
    assign rxParityErr = r_perr;
    assign rxBreak     = r_brk;
    assign out         = r_out;

endmodule
